// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS-subset control unit: fetch/decode/exec/mem/writeback sequencing,
// decoded ALU-control fields latched per instruction, and a retired-instruction counter.
module mc_control_unit #(
    parameter int unsigned ALUC_W   = 4,
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [5:0]        op,
    input  logic [5:0]        func,
    input  logic              z,
    input  logic              mem_ready,
    output logic [1:0]        pcsrc,
    output logic              pc_we,
    output logic              ir_we,
    output logic              mem_req,
    output logic              wmem,
    output logic              wreg,
    output logic [ALUC_W-1:0] aluc,
    output logic              shift,
    output logic              sext,
    output logic              aluimm,
    output logic              regrt,
    output logic              m2reg,
    output logic              jal,
    output logic [2:0]        state,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        ClsAlu, ClsBeq, ClsBne, ClsLw, ClsSw, ClsJ, ClsJal, ClsJr, ClsIll
    } cls_e;

    state_e            state_q, state_d;
    cls_e              cls_q, cls_d, dec_cls;
    // Field bundle: {aluc[3:0], shift, sext, aluimm, regrt, m2reg, jal}
    logic [9:0]        fld_q, fld_d, dec_fld;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              mem_done;

    assign mem_done = (MEM_WAIT == 0) ? 1'b1 : mem_ready;

    always_comb begin
        dec_cls = ClsIll;
        dec_fld = '0;
        case (op)
            6'b000000: begin
                dec_cls = ClsAlu;
                case (func)
                    6'b100000: dec_fld = {4'b0000, 6'b000000};
                    6'b100010: dec_fld = {4'b0100, 6'b000000};
                    6'b100100: dec_fld = {4'b0001, 6'b000000};
                    6'b100101: dec_fld = {4'b0101, 6'b000000};
                    6'b100110: dec_fld = {4'b0010, 6'b000000};
                    6'b000000: dec_fld = {4'b0011, 6'b100000};
                    6'b000010: dec_fld = {4'b0111, 6'b100000};
                    6'b000011: dec_fld = {4'b1111, 6'b100000};
                    6'b001000: dec_cls = ClsJr;
                    default:   dec_cls = ClsIll;
                endcase
            end
            6'b001000: begin dec_cls = ClsAlu; dec_fld = {4'b0000, 6'b011100}; end
            6'b001100: begin dec_cls = ClsAlu; dec_fld = {4'b0001, 6'b001100}; end
            6'b001101: begin dec_cls = ClsAlu; dec_fld = {4'b0101, 6'b001100}; end
            6'b001110: begin dec_cls = ClsAlu; dec_fld = {4'b0010, 6'b001100}; end
            6'b001111: begin dec_cls = ClsAlu; dec_fld = {4'b0110, 6'b001100}; end
            6'b100011: begin dec_cls = ClsLw;  dec_fld = {4'b0000, 6'b011110}; end
            6'b101011: begin dec_cls = ClsSw;  dec_fld = {4'b0000, 6'b011000}; end
            6'b000100: begin dec_cls = ClsBeq; dec_fld = {4'b0010, 6'b010000}; end
            6'b000101: begin dec_cls = ClsBne; dec_fld = {4'b0010, 6'b010000}; end
            6'b000010: dec_cls = ClsJ;
            6'b000011: begin dec_cls = ClsJal; dec_fld = {4'b0000, 6'b000001}; end
            default:   dec_cls = ClsIll;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        fld_d     = fld_q;
        retired_d = retired_q;
        pcsrc     = 2'b00;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        mem_req   = 1'b0;
        wmem      = 1'b0;
        wreg      = 1'b0;
        case (state_q)
            StFetch: begin
                mem_req = 1'b1;
                if (mem_done) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (dec_cls == ClsIll) begin
                    state_d = StTrap;
                end else begin
                    fld_d = dec_fld;
                    cls_d = dec_cls;
                    case (dec_cls)
                        ClsJ:    begin pc_we = 1'b1; pcsrc = 2'b11; state_d = StFetch; end
                        ClsJr:   begin pc_we = 1'b1; pcsrc = 2'b10; state_d = StFetch; end
                        ClsJal:  begin pc_we = 1'b1; pcsrc = 2'b11; state_d = StWb;    end
                        default: state_d = StExec;
                    endcase
                end
            end
            StExec: begin
                case (cls_q)
                    ClsBeq: begin
                        pc_we   = z;
                        pcsrc   = z ? 2'b01 : 2'b00;
                        state_d = StFetch;
                    end
                    ClsBne: begin
                        pc_we   = ~z;
                        pcsrc   = z ? 2'b00 : 2'b01;
                        state_d = StFetch;
                    end
                    ClsLw, ClsSw: state_d = StMem;
                    default:      state_d = StWb;
                endcase
            end
            StMem: begin
                mem_req = 1'b1;
                wmem    = (cls_q == ClsSw);
                if (mem_done) begin
                    state_d = (cls_q == ClsSw) ? StFetch : StWb;
                end
            end
            StWb: begin
                wreg    = 1'b1;
                state_d = StFetch;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase

        // Retire on every completed instruction; FETCH->FETCH waits do not count.
        if (state_d == StFetch && state_q != StFetch && state_q != StTrap) begin
            retired_d = retired_q + CNT_W'(1);
        end

        if (!resetn) begin
            pcsrc   = 2'b00;
            pc_we   = 1'b0;
            ir_we   = 1'b0;
            mem_req = 1'b0;
            wmem    = 1'b0;
            wreg    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= StFetch;
            cls_q     <= ClsAlu;
            fld_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            fld_q     <= fld_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign illegal = (state_q == StTrap);
    assign retired = retired_q;
    assign aluc    = ALUC_W'(fld_q[9:6]);
    assign shift   = fld_q[5];
    assign sext    = fld_q[4];
    assign aluimm  = fld_q[3];
    assign regrt   = fld_q[2];
    assign m2reg   = fld_q[1];
    assign jal     = fld_q[0];

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: instruction-level reference model that expands each instruction
// into its expected per-cycle outputs, plus directed corner sequences.
module tb_mc_control_unit;

    localparam int KAlu = 0, KBeq = 1, KBne = 2, KLw = 3, KSw = 4;
    localparam int KJ = 5, KJal = 6, KJr = 7, KIll = 8;

    typedef struct {
        logic [5:0] op;
        logic [5:0] func;
        logic [9:0] fld;   // {aluc[3:0], shift, sext, aluimm, regrt, m2reg, jal}
        int         kind;
    } vec_t;

    typedef struct {
        logic [2:0] st;
        logic [1:0] pcsrc;
        logic [5:0] str;   // {pc_we, ir_we, mem_req, wmem, wreg, illegal}
        logic       mr;
        logic       newf;
    } cyc_t;

    logic clk, resetn, z, mem_ready, mem_ready_nw;
    logic [5:0] op, func;

    logic [1:0] pcsrc;
    logic pc_we, ir_we, mem_req, wmem, wreg, shift, sext, aluimm, regrt, m2reg, jal, illegal;
    logic [3:0] aluc;
    logic [2:0] state;
    logic [15:0] retired;

    logic [1:0] c2_pcsrc;
    logic c2_pc_we, c2_ir_we, c2_mem_req, c2_wmem, c2_wreg, c2_shift, c2_sext, c2_aluimm;
    logic c2_regrt, c2_m2reg, c2_jal, c2_illegal;
    logic [3:0] c2_aluc;
    logic [2:0] c2_state;
    logic [1:0] c2_retired;

    logic [1:0] nw_pcsrc;
    logic nw_pc_we, nw_ir_we, nw_mem_req, nw_wmem, nw_wreg, nw_shift, nw_sext, nw_aluimm;
    logic nw_regrt, nw_m2reg, nw_jal, nw_illegal;
    logic [3:0] nw_aluc;
    logic [2:0] nw_state;
    logic [15:0] nw_retired;

    mc_control_unit dut (
        .clk(clk), .resetn(resetn), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
        .pcsrc(pcsrc), .pc_we(pc_we), .ir_we(ir_we), .mem_req(mem_req), .wmem(wmem),
        .wreg(wreg), .aluc(aluc), .shift(shift), .sext(sext), .aluimm(aluimm),
        .regrt(regrt), .m2reg(m2reg), .jal(jal), .state(state), .illegal(illegal),
        .retired(retired)
    );

    mc_control_unit #(.CNT_W(2)) dut_c2 (
        .clk(clk), .resetn(resetn), .op(op), .func(func), .z(z), .mem_ready(mem_ready),
        .pcsrc(c2_pcsrc), .pc_we(c2_pc_we), .ir_we(c2_ir_we), .mem_req(c2_mem_req),
        .wmem(c2_wmem), .wreg(c2_wreg), .aluc(c2_aluc), .shift(c2_shift), .sext(c2_sext),
        .aluimm(c2_aluimm), .regrt(c2_regrt), .m2reg(c2_m2reg), .jal(c2_jal),
        .state(c2_state), .illegal(c2_illegal), .retired(c2_retired)
    );

    mc_control_unit #(.MEM_WAIT(0)) dut_nw (
        .clk(clk), .resetn(resetn), .op(op), .func(func), .z(z), .mem_ready(mem_ready_nw),
        .pcsrc(nw_pcsrc), .pc_we(nw_pc_we), .ir_we(nw_ir_we), .mem_req(nw_mem_req),
        .wmem(nw_wmem), .wreg(nw_wreg), .aluc(nw_aluc), .shift(nw_shift), .sext(nw_sext),
        .aluimm(nw_aluimm), .regrt(nw_regrt), .m2reg(nw_m2reg), .jal(nw_jal),
        .state(nw_state), .illegal(nw_illegal), .retired(nw_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    vec_t tbl[19];
    vec_t cur_f;
    int   ret_m;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [5:0] o, input logic [5:0] f,
                                 input logic [3:0] a, input logic [5:0] b, input int k);
        vec_t v;
        v.op = o; v.func = f; v.fld = {a, b}; v.kind = k;
        return v;
    endfunction

    function automatic cyc_t mk(input logic [2:0] st, input logic [1:0] ps,
                                input logic [5:0] str, input logic mr, input logic nf);
        cyc_t c;
        c.st = st; c.pcsrc = ps; c.str = str; c.mr = mr; c.newf = nf;
        return c;
    endfunction

    function automatic int find(input logic [5:0] o, input logic [5:0] f);
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].op == o && (o != 6'd0 || tbl[i].func == f)) return i;
        end
        return -1;
    endfunction

    function automatic logic [10:0] ctl_now();
        return {state, pcsrc, pc_we, ir_we, mem_req, wmem, wreg, illegal};
    endfunction

    function automatic logic [9:0] fld_now();
        return {aluc, shift, sext, aluimm, regrt, m2reg, jal};
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        mem_ready = 1'($urandom);
        @(posedge clk); #1;
        check("rst_ctl", 32'(ctl_now()), 32'd0);
        check("rst_fld", 32'(fld_now()), 32'd0);
        check("rst_ret", 32'(retired), 32'd0);
        check("rst_ret_c2", 32'(c2_retired), 32'd0);
        resetn = 1'b1;
        cur_f = mkv(6'd0, 6'd0, 4'd0, 6'd0, KAlu);
        ret_m = 0;
    endtask

    // Expand one instruction into its expected cycles and apply them; cut < 0 runs it fully.
    task automatic run_instr(input vec_t v, input logic zz, input int fw, input int mw,
                             input int cut);
        cyc_t q[$];
        int   lim;
        q = {};
        for (int i = 0; i < fw; i++) q.push_back(mk(3'd0, 2'b00, 6'b001000, 1'b0, 1'b0));
        q.push_back(mk(3'd0, 2'b00, 6'b111000, 1'b1, 1'b0));
        case (v.kind)
            KIll: begin
                q.push_back(mk(3'd1, 2'b00, 6'b000000, 1'($urandom), 1'b0));
                for (int i = 0; i < 10; i++)
                    q.push_back(mk(3'd5, 2'b00, 6'b000001, 1'($urandom), 1'b0));
            end
            KJ:  q.push_back(mk(3'd1, 2'b11, 6'b100000, 1'($urandom), 1'b0));
            KJr: q.push_back(mk(3'd1, 2'b10, 6'b100000, 1'($urandom), 1'b0));
            KJal: begin
                q.push_back(mk(3'd1, 2'b11, 6'b100000, 1'($urandom), 1'b0));
                q.push_back(mk(3'd4, 2'b00, 6'b000010, 1'($urandom), 1'b1));
            end
            default: begin
                q.push_back(mk(3'd1, 2'b00, 6'b000000, 1'($urandom), 1'b0));
                case (v.kind)
                    KBeq: q.push_back(mk(3'd2, zz ? 2'b01 : 2'b00, {zz, 5'b0},
                                         1'($urandom), 1'b1));
                    KBne: q.push_back(mk(3'd2, zz ? 2'b00 : 2'b01, {~zz, 5'b0},
                                         1'($urandom), 1'b1));
                    KLw, KSw: begin
                        q.push_back(mk(3'd2, 2'b00, 6'b000000, 1'($urandom), 1'b1));
                        for (int i = 0; i < mw; i++)
                            q.push_back(mk(3'd3, 2'b00, {3'b001, v.kind == KSw, 2'b00},
                                           1'b0, 1'b1));
                        q.push_back(mk(3'd3, 2'b00, {3'b001, v.kind == KSw, 2'b00}, 1'b1, 1'b1));
                        if (v.kind == KLw)
                            q.push_back(mk(3'd4, 2'b00, 6'b000010, 1'($urandom), 1'b1));
                    end
                    default: begin
                        q.push_back(mk(3'd2, 2'b00, 6'b000000, 1'($urandom), 1'b1));
                        q.push_back(mk(3'd4, 2'b00, 6'b000010, 1'($urandom), 1'b1));
                    end
                endcase
            end
        endcase

        op = v.op; func = v.func; z = zz;
        lim = (cut < 0) ? q.size() : cut;
        for (int i = 0; i < lim; i++) begin
            mem_ready = q[i].mr;
            @(negedge clk);
            check("ctl", 32'(ctl_now()), 32'({q[i].st, q[i].pcsrc, q[i].str}));
            check("fields", 32'(fld_now()), 32'(q[i].newf ? v.fld : cur_f.fld));
            check("retired", 32'(retired), 32'(ret_m[15:0]));
            check("retired_c2", 32'(c2_retired), 32'(ret_m[1:0]));
            cyc++;
            @(posedge clk); #1;
        end
        if (cut < 0 && v.kind != KIll) begin
            cur_f = v;
            ret_m++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int   c2_seq[5];
        int   nw_st[10];
        vec_t v;
        int   idx;

        tbl[0]  = mkv(6'b000000, 6'b100000, 4'b0000, 6'b000000, KAlu);  // add
        tbl[1]  = mkv(6'b000000, 6'b100010, 4'b0100, 6'b000000, KAlu);  // sub
        tbl[2]  = mkv(6'b000000, 6'b100100, 4'b0001, 6'b000000, KAlu);  // and
        tbl[3]  = mkv(6'b000000, 6'b100101, 4'b0101, 6'b000000, KAlu);  // or
        tbl[4]  = mkv(6'b000000, 6'b100110, 4'b0010, 6'b000000, KAlu);  // xor
        tbl[5]  = mkv(6'b000000, 6'b000000, 4'b0011, 6'b100000, KAlu);  // sll
        tbl[6]  = mkv(6'b000000, 6'b000010, 4'b0111, 6'b100000, KAlu);  // srl
        tbl[7]  = mkv(6'b000000, 6'b000011, 4'b1111, 6'b100000, KAlu);  // sra
        tbl[8]  = mkv(6'b000000, 6'b001000, 4'b0000, 6'b000000, KJr);   // jr
        tbl[9]  = mkv(6'b001000, 6'b000000, 4'b0000, 6'b011100, KAlu);  // addi
        tbl[10] = mkv(6'b001100, 6'b000000, 4'b0001, 6'b001100, KAlu);  // andi
        tbl[11] = mkv(6'b001101, 6'b000000, 4'b0101, 6'b001100, KAlu);  // ori
        tbl[12] = mkv(6'b001110, 6'b000000, 4'b0010, 6'b001100, KAlu);  // xori
        tbl[13] = mkv(6'b001111, 6'b000000, 4'b0110, 6'b001100, KAlu);  // lui
        tbl[14] = mkv(6'b100011, 6'b000000, 4'b0000, 6'b011110, KLw);   // lw
        tbl[15] = mkv(6'b101011, 6'b000000, 4'b0000, 6'b011000, KSw);   // sw
        tbl[16] = mkv(6'b000100, 6'b000000, 4'b0010, 6'b010000, KBeq);  // beq
        tbl[17] = mkv(6'b000101, 6'b000000, 4'b0010, 6'b010000, KBne);  // bne
        tbl[18] = mkv(6'b000010, 6'b000000, 4'b0000, 6'b000000, KJ);    // j
        c2_seq = '{1, 2, 3, 0, 1};
        nw_st  = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 0};

        resetn = 1'b0; op = 6'd0; func = 6'd0; z = 1'b0;
        mem_ready = 1'b0; mem_ready_nw = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Whole decode table, plus both outcomes of each branch and a jal.
        for (int i = 0; i < 19; i++)
            run_instr(tbl[i], 1'($urandom), int'($urandom % 3), int'($urandom % 3), -1);
        run_instr(tbl[16], 1'b1, 0, 0, -1);
        run_instr(tbl[16], 1'b0, 0, 0, -1);
        run_instr(tbl[17], 1'b1, 0, 0, -1);
        run_instr(tbl[17], 1'b0, 0, 0, -1);
        run_instr(mkv(6'b000011, 6'b000000, 4'b0000, 6'b000001, KJal), 1'b0, 1, 0, -1);
        run_instr(tbl[14], 1'b0, 0, 3, -1);

        // Counter wrap in the 2-bit instance.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            run_instr(tbl[0], 1'b0, 0, 0, -1);
            check("c2_wrap", 32'(c2_retired), 32'(c2_seq[k]));
        end

        // Reset in the middle of a MEM wait.
        run_instr(tbl[14], 1'b0, 0, 6, 6);
        do_reset();

        // Illegal opcodes trap until reset.
        run_instr(mkv(6'b111111, 6'b000000, 4'b0000, 6'b000000, KIll), 1'b0, 0, 0, -1);
        do_reset();
        run_instr(tbl[1], 1'b0, 0, 0, -1);
        run_instr(mkv(6'b000000, 6'b111111, 4'b0000, 6'b000000, KIll), 1'b0, 2, 0, -1);
        do_reset();

        // Randomized instruction stream.
        for (int n = 0; n < 300; n++) begin
            if ($urandom % 12 == 0) begin
                v = mkv(6'($urandom), 6'($urandom), 4'd0, 6'd0, KIll);
                while (find(v.op, v.func) >= 0) begin
                    v.op = 6'($urandom);
                    v.func = 6'($urandom);
                end
                run_instr(v, 1'($urandom), int'($urandom % 3), 0, -1);
                do_reset();
            end else begin
                idx = int'($urandom % 19);
                v = (idx == 18 && ($urandom % 2 == 0))
                    ? mkv(6'b000011, 6'b000000, 4'b0000, 6'b000001, KJal) : tbl[idx];
                if (v.op != 6'd0) v.func = 6'($urandom);
                run_instr(v, 1'($urandom), int'($urandom % 3), int'($urandom % 4), -1);
            end
        end

        // MEM_WAIT=0 instance: sw then lw with mem_ready held low.
        do_reset();
        mem_ready = 1'b0;
        mem_ready_nw = 1'b0;
        op = 6'b101011;
        func = 6'd0;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) op = 6'b100011;
            @(negedge clk);
            check("nw_state", 32'(nw_state), 32'(nw_st[k]));
            if (k == 3) check("nw_sw_mem", 32'({nw_mem_req, nw_wmem}), 32'd3);
            if (k == 4) check("nw_ret_sw", 32'(nw_retired), 32'd1);
            if (k == 8) check("nw_lw_wb", 32'({nw_wreg, nw_m2reg}), 32'd3);
            if (k == 9) check("nw_ret_lw", 32'(nw_retired), 32'd2);
            cyc++;
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameter ALUC_W, default 4, ALU-control width (>=4); codes are zero-extended to ALUC_W.
REQ-002 Parameter MEM_WAIT, default 1, meaning: 1 = honour mem_ready, 0 = treat mem_ready as constant 1.
REQ-003 Parameter CNT_W, default 16, retired-instruction counter width.
REQ-004 Ports (name direction width meaning): clk in 1 clock; resetn in 1 synchronous active-low reset; op in 6 IR opcode; func in 6 IR function; z in 1 ALU zero; mem_ready in 1 memory done.
REQ-005 Outputs: pcsrc out 2 PC mux (00 seq, 01 branch, 10 jr, 11 jump); pc_we out 1; ir_we out 1; mem_req out 1; wmem out 1; wreg out 1.
REQ-006 Outputs: aluc out ALUC_W; shift, sext, aluimm, regrt, m2reg, jal out 1 each; state out 3; illegal out 1; retired out CNT_W.
REQ-007 Clocking: one clock, clk; reset is synchronous and active-low, resetn, sampled on rising clk edge.

Function
REQ-008 States/encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; state output equals current state.
REQ-009 FETCH: mem_req=1; on mem_ready pulse ir_we=1, pc_we=1, pcsrc=00 for that cycle, go DECODE; otherwise hold FETCH.
REQ-010 DECODE: classify op/func; latch aluc, shift, sext, aluimm, regrt, m2reg, jal into registers held until next DECODE.
REQ-011 Decode table (aluc): add 0000, sub 0100, and 0001, or 0101, xor 0010, sll 0011 shift=1, srl 0111 shift=1, sra 1111 shift=1 (all op=0, regrt=0, aluimm=0).
REQ-012 I-type: addi 001000 aluc 0000 sext=1; andi 001100 0001; ori 001101 0101; xori 001110 0010 (sext=0); lui 001111 0110; all aluimm=1 regrt=1.
REQ-013 lw 100011 / sw 101011: aluc 0000, sext=1, aluimm=1; lw m2reg=1 regrt=1; beq 000100 / bne 000101: aluc 0010, sext=1, aluimm=0.
REQ-014 Jumps: j 000010, jal 000011 (jal=1), jr = op 0 func 001000.
REQ-015 Illegal: any op or op-0 func not listed in REQ-011..014; DECODE -> TRAP, latched fields unchanged.
REQ-016 DECODE exits: j -> FETCH with pc_we=1 pcsrc=11; jr -> FETCH with pc_we=1 pcsrc=10; jal -> WB with pc_we=1 pcsrc=11; all others -> EXEC.
REQ-017 EXEC: beq -> FETCH, pc_we=z, pcsrc=01 if z else 00; bne -> FETCH, pc_we=~z, pcsrc=01 if ~z else 00; lw/sw -> MEM; ALU ops -> WB.
REQ-018 MEM: mem_req=1; wmem=1 every MEM cycle for sw only; on mem_ready: sw -> FETCH, lw -> WB; otherwise hold MEM.
REQ-019 WB: wreg=1 exactly one cycle, then FETCH.
REQ-020 wreg, wmem, pc_we, ir_we, mem_req are 0 in every state/condition not listed above.
REQ-021 retired increments by 1 (wrapping modulo 2^CNT_W) on every transition into FETCH from DECODE, EXEC, MEM or WB.
REQ-022 TRAP: illegal=1; all strobes 0; stays in TRAP until reset; retired frozen.
REQ-023 MEM_WAIT=0: FETCH and MEM each last exactly one cycle regardless of mem_ready.
REQ-024 pcsrc reads 00 whenever pc_we=0.

Reset
REQ-025 resetn=0 at a clk edge: state=FETCH, all strobes 0, latched fields 0, illegal=0, retired=0, regardless of current state including MEM mid-wait or TRAP.
REQ-026 First cycle after reset release is FETCH with mem_req=1.

Verification
REQ-027 add (op 0, func 100000), mem_ready=1: states 0,1,2,4,0; wreg=1 only in WB; aluc=0000; retired 0->1.
REQ-028 lw with mem_ready low 3 cycles in MEM: MEM held 4 cycles, mem_req=1 throughout, wmem=0, then WB with m2reg=1 wreg=1.
REQ-029 beq z=1 -> EXEC pc_we=1 pcsrc=01; beq z=0 -> pc_we=0 pcsrc=00; bne inverse.
REQ-030 jal: DECODE pc_we=1 pcsrc=11, WB wreg=1 jal=1; jr (func 001000): DECODE pc_we=1 pcsrc=10, no WB.
REQ-031 op 111111: DECODE -> TRAP, illegal=1, retired frozen for 10 cycles; resetn=0 returns state=0, illegal=0.
REQ-032 CNT_W=2, five add instructions: retired sequence 1,2,3,0,1; MEM_WAIT=0 with mem_ready=0: sw completes in 4 cycles.
